rename_register_file: RTL and testbench
=======================================

Name: rename_register_file

Overview:
- Architectural register file with per-register rename tags.
- Sits between the dispatcher and the reorder buffer.
- Dispatcher side: supplies source-operand values or pending ROB tags for two sources, and records the destination rename of each newly issued instruction.
- ROB side: the receiving end of the commit interface (rd, V, Q, commit_flag) and of the rollback broadcast.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired zero)
DATA_WIDTH, 32, register data width
ROB_ID_WIDTH, 6, rename tag width; tag 0 = "no pending producer", tag k = ROB slot k-1

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; when low, all state holds
rs1_from_dispatcher  input  5  source 1 register index
rs2_from_dispatcher  input  5  source 2 register index
V1_to_dispatcher  output  DATA_WIDTH  source 1 value (valid when Q1 = 0)
Q1_to_dispatcher  output  ROB_ID_WIDTH  source 1 pending tag, 0 if value ready
V2_to_dispatcher  output  DATA_WIDTH  source 2 value
Q2_to_dispatcher  output  ROB_ID_WIDTH  source 2 pending tag
rename_enable_from_dispatcher  input  1  record a destination rename this cycle
rd_from_dispatcher  input  5  destination register being renamed
rob_id_from_dispatcher  input  ROB_ID_WIDTH  ROB tag (slot+1) of the renaming instruction
commit_flag  input  1  ROB commit pulse
rd_from_rob  input  5  committed destination register
V_from_rob  input  DATA_WIDTH  committed value
Q_from_rob  input  ROB_ID_WIDTH  ROB tag of the committed instruction
rollback_flag  input  1  misprediction flush broadcast

Behaviour:
- State: data[REG_NUM], tag[REG_NUM]. Reset (rst_in high at posedge) clears all data and tags to 0.
- rst_in has priority over rdy_in. When rdy_in is low and rst_in is low, no state changes.
- Read ports are combinational, zero latency. For each source rsN:
  - rsN = 0 -> V = 0, Q = 0.
  - Else if commit_flag && rd_from_rob = rsN && tag[rsN] = Q_from_rob (bypass) -> V = V_from_rob, Q = 0.
  - Else if tag[rsN] != 0 -> V = data[rsN], Q = tag[rsN].
  - Else -> V = data[rsN], Q = 0.
- Outputs after reset: V = 0 and Q = 0 for every index.
- Reads never see a same-cycle rename. An instruction whose destination equals its own source (e.g. addi x1,x1,1) reads the previous tag.
- Commit, at posedge with rdy_in and commit_flag, and rd_from_rob != 0:
  - data[rd] <= V_from_rob, unconditionally. This is in-order commit, so it is always the newest architectural value.
  - If tag[rd] = Q_from_rob, then tag[rd] <= 0. Otherwise the tag is kept, because a younger producer owns the register.
- Rename, at posedge with rdy_in and rename_enable, and rd_from_dispatcher != 0:
  - tag[rd] <= rob_id_from_dispatcher.
  - If rename and commit target the same rd in the same cycle, the rename tag wins; the commit data write still occurs.
- Writes to x0 (commit or rename) are ignored. data[0] and tag[0] stay 0.
- Rollback, at posedge with rdy_in and rollback_flag:
  - All tags <= 0.
  - Rename in the same cycle is ignored.
  - A commit asserted in the same cycle as rollback still writes data. The ROB asserts both for the mispredicted jump's own commit.
- A tag equal to Q_from_rob on a register other than rd_from_rob is unaffected.
- No internal counters. The block holds no ROB-occupancy state, so wrap-around of ROB tags (0x20 -> 0x01) needs no handling.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> V1=0, Q1=0, V2=0, Q2=0. Rename rd=0 tag 3 -> a subsequent read of x0 returns Q=0.
- Rename x5 with tag 0x07, next cycle read rs1=5 -> Q1=0x07. Commit rd=5 V=0xDEADBEEF Q=0x07 -> same-cycle bypass read gives V1=0xDEADBEEF, Q1=0. Next cycle tag[5]=0 and data[5]=0xDEADBEEF.
- Rename x3 to tag 0x04, then to tag 0x09. Commit rd=3 Q=0x04 V=0x11 -> data[3]=0x11, Q=0x09 retained, and the bypass is not taken for a read of x3 (V=0x11 visible next cycle, Q=0x09).
- Same-cycle rename x8 tag 0x0A and commit rd=8 Q=tag[8] V=0x22 -> tag[8]=0x0A, data[8]=0x22.
- Renames pending on x1, x2, x31; assert rollback_flag with commit rd=1 V=0x40 -> all Q read 0, data[1]=0x40. A rename issued in the same cycle is dropped.
- Hold rdy_in low while rename/commit inputs toggle -> no tag or data change. Assert rst_in with rdy_in low -> all state cleared.

Source files
------------

// File: rtl/rename_register_file.sv
// Architectural register file with per-register ROB rename tags.
// Combinational operand reads with commit bypass; commit, rename and rollback update state on clk_in.
module rename_register_file #(
    parameter int unsigned REG_NUM      = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ROB_ID_WIDTH = 6
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [4:0]              rs1_from_dispatcher,
    input  logic [4:0]              rs2_from_dispatcher,
    output logic [DATA_WIDTH-1:0]   V1_to_dispatcher,
    output logic [ROB_ID_WIDTH-1:0] Q1_to_dispatcher,
    output logic [DATA_WIDTH-1:0]   V2_to_dispatcher,
    output logic [ROB_ID_WIDTH-1:0] Q2_to_dispatcher,
    input  logic                    rename_enable_from_dispatcher,
    input  logic [4:0]              rd_from_dispatcher,
    input  logic [ROB_ID_WIDTH-1:0] rob_id_from_dispatcher,
    input  logic                    commit_flag,
    input  logic [4:0]              rd_from_rob,
    input  logic [DATA_WIDTH-1:0]   V_from_rob,
    input  logic [ROB_ID_WIDTH-1:0] Q_from_rob,
    input  logic                    rollback_flag
);

    logic [DATA_WIDTH-1:0]   data_q [REG_NUM];
    logic [ROB_ID_WIDTH-1:0] tag_q  [REG_NUM];

    logic commit_wr;
    logic rename_wr;

    assign commit_wr = commit_flag && (rd_from_rob != 5'd0);
    assign rename_wr = rename_enable_from_dispatcher && (rd_from_dispatcher != 5'd0) && !rollback_flag;

    // Source 1 read: x0 is zero, a matching commit is forwarded, otherwise stored value and tag.
    always_comb begin
        V1_to_dispatcher = '0;
        Q1_to_dispatcher = '0;
        if (rs1_from_dispatcher != 5'd0) begin
            if (commit_flag && (rd_from_rob == rs1_from_dispatcher)
                && (tag_q[rs1_from_dispatcher] == Q_from_rob)) begin
                V1_to_dispatcher = V_from_rob;
            end else begin
                V1_to_dispatcher = data_q[rs1_from_dispatcher];
                Q1_to_dispatcher = tag_q[rs1_from_dispatcher];
            end
        end
    end

    // Source 2 read, same rules as source 1.
    always_comb begin
        V2_to_dispatcher = '0;
        Q2_to_dispatcher = '0;
        if (rs2_from_dispatcher != 5'd0) begin
            if (commit_flag && (rd_from_rob == rs2_from_dispatcher)
                && (tag_q[rs2_from_dispatcher] == Q_from_rob)) begin
                V2_to_dispatcher = V_from_rob;
            end else begin
                V2_to_dispatcher = data_q[rs2_from_dispatcher];
                Q2_to_dispatcher = tag_q[rs2_from_dispatcher];
            end
        end
    end

    // Later assignments win: rollback clears over commit, rename overrides a same-rd commit clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (commit_wr) begin
                data_q[rd_from_rob] <= V_from_rob;
                if (tag_q[rd_from_rob] == Q_from_rob) begin
                    tag_q[rd_from_rob] <= '0;
                end
            end
            if (rollback_flag) begin
                for (int i = 0; i < int'(REG_NUM); i++) begin
                    tag_q[i] <= '0;
                end
            end
            if (rename_wr) begin
                tag_q[rd_from_dispatcher] <= rob_id_from_dispatcher;
            end
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Directed, table-driven bench for rename_register_file: each row drives one cycle,
// checks the combinational read ports before the edge, then lets the edge apply the writes.
module tb_rename_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [4:0]  rs1_from_dispatcher, rs2_from_dispatcher;
    logic [31:0] V1_to_dispatcher, V2_to_dispatcher;
    logic [5:0]  Q1_to_dispatcher, Q2_to_dispatcher;
    logic        rename_enable_from_dispatcher;
    logic [4:0]  rd_from_dispatcher;
    logic [5:0]  rob_id_from_dispatcher;
    logic        commit_flag;
    logic [4:0]  rd_from_rob;
    logic [31:0] V_from_rob;
    logic [5:0]  Q_from_rob;
    logic        rollback_flag;

    int checks = 0;
    int errors = 0;

    rename_register_file dut (
        .clk_in                        (clk_in),
        .rst_in                        (rst_in),
        .rdy_in                        (rdy_in),
        .rs1_from_dispatcher           (rs1_from_dispatcher),
        .rs2_from_dispatcher           (rs2_from_dispatcher),
        .V1_to_dispatcher              (V1_to_dispatcher),
        .Q1_to_dispatcher              (Q1_to_dispatcher),
        .V2_to_dispatcher              (V2_to_dispatcher),
        .Q2_to_dispatcher              (Q2_to_dispatcher),
        .rename_enable_from_dispatcher (rename_enable_from_dispatcher),
        .rd_from_dispatcher            (rd_from_dispatcher),
        .rob_id_from_dispatcher        (rob_id_from_dispatcher),
        .commit_flag                   (commit_flag),
        .rd_from_rob                   (rd_from_rob),
        .V_from_rob                    (V_from_rob),
        .Q_from_rob                    (Q_from_rob),
        .rollback_flag                 (rollback_flag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ren;
        logic [4:0]  rd;
        logic [5:0]  rid;
        logic        cf;
        logic [4:0]  crd;
        logic [31:0] cv;
        logic [5:0]  cq;
        logic        rb;
        logic [31:0] ev1;
        logic [5:0]  eq1;
        logic [31:0] ev2;
        logic [5:0]  eq2;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rename_enable_from_dispatcher = 1'b0;
        rd_from_dispatcher            = 5'd0;
        rob_id_from_dispatcher        = 6'd0;
        commit_flag                   = 1'b0;
        rd_from_rob                   = 5'd0;
        V_from_rob                    = 32'd0;
        Q_from_rob                    = 6'd0;
        rollback_flag                 = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] ev1, input logic [5:0] eq1,
                              input logic [31:0] ev2, input logic [5:0] eq2);
        rs1_from_dispatcher = r1;
        rs2_from_dispatcher = r2;
        #1;
        check({name, "_V1"}, V1_to_dispatcher, ev1);
        check({name, "_Q1"}, 32'(Q1_to_dispatcher), 32'(eq1));
        check({name, "_V2"}, V2_to_dispatcher, ev2);
        check({name, "_Q2"}, 32'(Q2_to_dispatcher), 32'(eq2));
    endtask

    initial begin
        // rs1 rs2 | ren rd rid | cf crd cv cq | rb | ev1 eq1 ev2 eq2
        vecs[0]  = '{5, 0,  1, 0, 3,      0, 0, 0, 0,              0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0,  1, 5, 7,      0, 0, 0, 0,              0, 0, 0, 0, 0};
        vecs[2]  = '{5, 5,  0, 0, 0,      0, 0, 0, 0,              0, 0, 7, 0, 7};
        vecs[3]  = '{5, 0,  0, 0, 0,      1, 5, 32'hDEADBEEF, 7,   0, 32'hDEADBEEF, 0, 0, 0};
        vecs[4]  = '{5, 3,  1, 3, 4,      0, 0, 0, 0,              0, 32'hDEADBEEF, 0, 0, 0};
        vecs[5]  = '{3, 5,  1, 3, 9,      0, 0, 0, 0,              0, 0, 4, 32'hDEADBEEF, 0};
        vecs[6]  = '{3, 3,  0, 0, 0,      1, 3, 32'h11, 4,         0, 0, 9, 0, 9};
        vecs[7]  = '{3, 8,  1, 8, 6'h0A,  1, 8, 32'h22, 0,         0, 32'h11, 9, 32'h22, 0};
        vecs[8]  = '{8, 1,  1, 1, 6'h0B,  0, 0, 0, 0,              0, 32'h22, 6'h0A, 0, 0};
        vecs[9]  = '{1, 2,  1, 2, 6'h0C,  0, 0, 0, 0,              0, 0, 6'h0B, 0, 0};
        vecs[10] = '{2, 31, 1, 31, 6'h0D, 0, 0, 0, 0,              0, 0, 6'h0C, 0, 0};
        vecs[11] = '{31, 1, 1, 4, 6'h0E,  1, 1, 32'h40, 6'h0B,     1, 0, 6'h0D, 32'h40, 0};
        vecs[12] = '{1, 31, 0, 0, 0,      0, 0, 0, 0,              0, 32'h40, 0, 0, 0};
        vecs[13] = '{4, 2,  0, 0, 0,      0, 0, 0, 0,              0, 0, 0, 0, 0};
        vecs[14] = '{8, 3,  0, 0, 0,      0, 0, 0, 0,              0, 32'h22, 0, 32'h11, 0};
        vecs[15] = '{6, 0,  1, 6, 6'h10,  0, 0, 0, 0,              0, 0, 0, 0, 0};
        vecs[16] = '{6, 7,  0, 0, 0,      1, 7, 32'h33, 6'h10,     0, 0, 6'h10, 0, 0};
        vecs[17] = '{6, 7,  0, 0, 0,      1, 0, 32'h55, 0,         0, 0, 6'h10, 32'h33, 0};
        vecs[18] = '{0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 0, 0, 0, 0};

        drive_idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        rs1_from_dispatcher = 5'd0;
        rs2_from_dispatcher = 5'd0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            rename_enable_from_dispatcher = vecs[i].ren;
            rd_from_dispatcher            = vecs[i].rd;
            rob_id_from_dispatcher        = vecs[i].rid;
            commit_flag                   = vecs[i].cf;
            rd_from_rob                   = vecs[i].crd;
            V_from_rob                    = vecs[i].cv;
            Q_from_rob                    = vecs[i].cq;
            rollback_flag                 = vecs[i].rb;
            read_check($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2,
                       vecs[i].ev1, vecs[i].eq1, vecs[i].ev2, vecs[i].eq2);
            @(negedge clk_in);
        end
        drive_idle();

        // rdy_in low: toggling rename/commit/rollback must not touch state
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rename_enable_from_dispatcher = 1'b1;
            rd_from_dispatcher            = 5'd5;
            rob_id_from_dispatcher        = 6'(6'h11 + c);
            commit_flag                   = 1'b1;
            rd_from_rob                   = 5'd6;
            V_from_rob                    = 32'h66 + 32'(c);
            Q_from_rob                    = 6'h10;
            rollback_flag                 = c[0];
            @(negedge clk_in);
        end
        drive_idle();
        rdy_in = 1'b1;
        read_check("hold", 5'd5, 5'd6, 32'hDEADBEEF, 6'h00, 32'h0, 6'h10);

        // reset with rdy_in low still clears everything
        rdy_in = 1'b0;
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        read_check("rst_a", 5'd5, 5'd6, 32'h0, 6'h0, 32'h0, 6'h0);
        read_check("rst_b", 5'd3, 5'd1, 32'h0, 6'h0, 32'h0, 6'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
